// File: rtl/jpeg_pkg.sv
// ---------------------------------------------------------------------------
// jpeg_pkg
//   Definitions shared by the JPEG zigzag / de-zigzag buffers.
//   BLK_DEPTH    : coefficients per 8x8 block
//   IDX_W        : width of a coefficient index within a block
//   bank_state_t : per-bank fill state (EMPTY -> FILLING -> FULL -> EMPTY)
//   ZZ_TO_NAT    : zigzag scan index -> natural raster index (row*8+col)
// ---------------------------------------------------------------------------
package jpeg_pkg;

  localparam int unsigned BLK_DEPTH = 64;
  localparam int unsigned IDX_W     = 6;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    FILLING = 2'd1,
    FULL    = 2'd2
  } bank_state_t;

  // Ascending packed range so element 0 is the first entry of the literal.
  localparam logic [0:BLK_DEPTH-1][IDX_W-1:0] ZZ_TO_NAT = {
    6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
    6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
    6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
    6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
    6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
    6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
    6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
    6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
  };

  function automatic logic [IDX_W-1:0] zz_to_nat(input logic [IDX_W-1:0] k);
    return ZZ_TO_NAT[k];
  endfunction

endpackage

// File: rtl/dezigzag_bank.sv
// ---------------------------------------------------------------------------
// dezigzag_bank
//   One ping-pong bank: 64-entry coefficient store with a write mask and a
//   fill-state FSM. Unwritten entries read back as zero through the mask.
// Ports
//   clock, reset_n : rising-edge clock, asynchronous active-low reset
//   we_i           : write data_i at natural index addr_i, set its mask bit
//   addr_i, data_i : write port
//   complete_i     : with we_i, this write finishes the block -> FULL
//   clear_i        : block consumed -> EMPTY, mask cleared
//   state_o        : current fill state
//   rd_data_o      : masked parallel read of all 64 entries
// ---------------------------------------------------------------------------
module dezigzag_bank
  import jpeg_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  we_i,
  input  logic [IDX_W-1:0]      addr_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  complete_i,
  input  logic                  clear_i,
  output bank_state_t           state_o,
  output logic [DATA_WIDTH-1:0] rd_data_o [0:BLK_DEPTH-1]
);

  bank_state_t            state_q, state_d;
  logic [BLK_DEPTH-1:0]   mask_q, mask_d;
  logic [DATA_WIDTH-1:0]  mem_q [0:BLK_DEPTH-1];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= EMPTY;
      mask_q  <= '0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      EMPTY:   if (we_i) state_d = complete_i ? FULL : FILLING;
      FILLING: if (we_i && complete_i) state_d = FULL;
      FULL:    if (clear_i) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  always_comb begin
    mask_d = mask_q;
    if (clear_i) begin
      mask_d = '0;
    end else if (we_i) begin
      mask_d[addr_i] = 1'b1;
    end
  end

  // Storage needs no reset: the mask hides anything not written this block.
  always_ff @(posedge clock) begin
    if (we_i) begin
      mem_q[addr_i] <= data_i;
    end
  end

  always_comb begin
    for (int unsigned n = 0; n < BLK_DEPTH; n++) begin
      rd_data_o[n] = mask_q[n] ? mem_q[n] : '0;
    end
  end

  assign state_o = state_q;

endmodule

// File: rtl/dezigzag_buffer_64x16bit.sv
// ---------------------------------------------------------------------------
// dezigzag_buffer_64x16bit
//   Collects coefficients arriving in zigzag order and presents each finished
//   8x8 block in raster order. Two banks ping-pong so one block can fill while
//   the previous one waits for the consumer.
// Ports
//   clock, reset_n      : rising-edge clock, asynchronous active-low reset
//   in_valid / in_ready : input handshake (in_ready from registered state only)
//   in_data             : coefficient at the current zigzag index
//   in_eob              : last nonzero coefficient of the block
//   out_valid/out_ready : block handshake
//   out_data            : completed block, index = row*8+col
// ---------------------------------------------------------------------------
module dezigzag_buffer_64x16bit
  import jpeg_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned DEPTH      = 64
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_eob,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data [0:DEPTH-1]
);

  logic              ready_en_q;
  logic [IDX_W-1:0]  k_q, k_d;
  logic              wr_sel_q, wr_sel_d;
  logic              rd_sel_q, rd_sel_d;

  bank_state_t       st0, st1;
  bank_state_t       wr_state, rd_state;
  logic [DATA_WIDTH-1:0] rd0 [0:BLK_DEPTH-1];
  logic [DATA_WIDTH-1:0] rd1 [0:BLK_DEPTH-1];

  logic              accept, last, out_fire;
  logic [IDX_W-1:0]  wr_addr;

  // Holds in_ready low through reset and until the first clock after release.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ready_en_q <= 1'b0;
    end else begin
      ready_en_q <= 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      k_q      <= '0;
      wr_sel_q <= 1'b0;
      rd_sel_q <= 1'b0;
    end else begin
      k_q      <= k_d;
      wr_sel_q <= wr_sel_d;
      rd_sel_q <= rd_sel_d;
    end
  end

  assign wr_state  = wr_sel_q ? st1 : st0;
  assign rd_state  = rd_sel_q ? st1 : st0;

  assign in_ready  = ready_en_q && (wr_state != FULL);
  assign out_valid = (rd_state == FULL);

  assign accept    = in_valid && in_ready;
  assign last      = accept && (in_eob || (k_q == IDX_W'(BLK_DEPTH - 1)));
  assign out_fire  = out_valid && out_ready;
  assign wr_addr   = zz_to_nat(k_q);

  always_comb begin
    k_d      = k_q;
    wr_sel_d = wr_sel_q;
    rd_sel_d = rd_sel_q;
    if (last) begin
      k_d      = '0;
      wr_sel_d = ~wr_sel_q;
    end else if (accept) begin
      k_d      = k_q + 1'b1;
    end
    if (out_fire) begin
      rd_sel_d = ~rd_sel_q;
    end
  end

  // A FULL bank is never written (in_ready is low), so write and clear
  // strobes can never land on the same bank in one cycle.
  dezigzag_bank #(.DATA_WIDTH(DATA_WIDTH)) u_bank0 (
    .clock      (clock),
    .reset_n    (reset_n),
    .we_i       (accept && !wr_sel_q),
    .addr_i     (wr_addr),
    .data_i     (in_data),
    .complete_i (last && !wr_sel_q),
    .clear_i    (out_fire && !rd_sel_q),
    .state_o    (st0),
    .rd_data_o  (rd0)
  );

  dezigzag_bank #(.DATA_WIDTH(DATA_WIDTH)) u_bank1 (
    .clock      (clock),
    .reset_n    (reset_n),
    .we_i       (accept && wr_sel_q),
    .addr_i     (wr_addr),
    .data_i     (in_data),
    .complete_i (last && wr_sel_q),
    .clear_i    (out_fire && rd_sel_q),
    .state_o    (st1),
    .rd_data_o  (rd1)
  );

  always_comb begin
    for (int unsigned n = 0; n < DEPTH; n++) begin
      out_data[n] = rd_sel_q ? rd1[n] : rd0[n];
    end
  end

endmodule

// File: tb/tb_dezigzag_buffer_64x16bit.sv
module tb_dezigzag_buffer_64x16bit;

  logic        clock;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        in_eob;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data [0:63];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  bit mon_en = 1'b0;
  int acc_cnt, first_acc, last_acc, hs_n;
  int hs_cyc [0:7];
  bit ready_low;

  dezigzag_buffer_64x16bit #(.DATA_WIDTH(16), .DEPTH(64)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_eob    (in_eob),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  always @(posedge clock) begin
    if (mon_en) begin
      if (in_valid && in_ready) begin
        if (acc_cnt == 0) first_acc = cyc;
        last_acc = cyc;
        acc_cnt++;
      end
      if (in_valid && !in_ready) ready_low = 1'b1;
      if (out_valid && out_ready) begin
        if (hs_n < 8) hs_cyc[hs_n] = cyc;
        hs_n++;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic send(input logic [15:0] d, input logic eob);
    int n;
    n        = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_eob   = eob;
    while (!in_ready && n < 300) begin
      @(posedge clock);
      #1;
      n++;
    end
    if (n >= 300) begin
      checks++;
      errors++;
      $error("FAIL send_timeout: observed in_ready=0 for %0d cycles, expected 1", n);
    end
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    in_eob   = 1'b0;
  endtask

  // Entries other than [0], [1], [8] that are nonzero.
  function automatic int stray_nonzero();
    int nz = 0;
    for (int i = 0; i < 64; i++)
      if (i != 0 && i != 1 && i != 8 && out_data[i] !== 16'h0000) nz++;
    return nz;
  endfunction

  // Counts values outside 0..63 or repeated: 0 means out_data is a permutation of 0..63.
  function automatic int perm_errors();
    logic [63:0] seen;
    int bad = 0;
    seen = '0;
    for (int i = 0; i < 64; i++) begin
      if (out_data[i] > 16'd63 || seen[out_data[i][5:0]]) bad++;
      else seen[out_data[i][5:0]] = 1'b1;
    end
    return bad;
  endfunction

  task automatic check_ramp_block(input string pfx);
    check({pfx, "_valid"}, out_valid, 1);
    check({pfx, "_d0"},  out_data[0],  16'd0);
    check({pfx, "_d1"},  out_data[1],  16'd1);
    check({pfx, "_d8"},  out_data[8],  16'd2);
    check({pfx, "_d16"}, out_data[16], 16'd3);
    check({pfx, "_d9"},  out_data[9],  16'd4);
    check({pfx, "_d2"},  out_data[2],  16'd5);
    check({pfx, "_d3"},  out_data[3],  16'd6);
    check({pfx, "_d10"}, out_data[10], 16'd7);
    check({pfx, "_d63"}, out_data[63], 16'd63);
    check({pfx, "_perm"}, perm_errors(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish by 500us, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [15:0] snap [0:63];
    int diffs;

    reset_n   = 1'b0;
    in_valid  = 1'b0;
    in_eob    = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;

    // Reset
    tick(3);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    reset_n = 1'b1;
    tick(1);
    check("post_rst_in_ready", in_ready, 1);
    check("post_rst_out_valid", out_valid, 0);

    // 1: full ramp block
    out_ready = 1'b1;
    for (int i = 0; i < 63; i++) send(16'(i), 1'b0);
    check("s1_valid_early", out_valid, 0);
    send(16'd63, 1'b0);
    check_ramp_block("s1");
    tick(1);
    check("s1_consumed", out_valid, 0);
    out_ready = 1'b0;

    // 2: short block ended by EOB
    send(16'd100, 1'b0);
    send(16'hFFFB, 1'b0);
    send(16'd7, 1'b1);
    check("s2_valid", out_valid, 1);
    check("s2_d0", out_data[0], 16'd100);
    check("s2_d1", out_data[1], 16'hFFFB);
    check("s2_d8", out_data[8], 16'd7);
    check("s2_zeros", stray_nonzero(), 0);
    out_ready = 1'b1;
    tick(1);
    out_ready = 1'b0;
    check("s2_consumed", out_valid, 0);
    send(16'h0055, 1'b1);
    check("s2_next_valid", out_valid, 1);
    check("s2_next_d0", out_data[0], 16'h0055);
    check("s2_next_d1", out_data[1], 16'h0000);
    out_ready = 1'b1;
    tick(1);
    out_ready = 1'b0;

    // 3: backpressure with both banks full
    for (int i = 0; i < 128; i++)
      send((i < 64) ? 16'(16'h0100 + i) : 16'(16'h0200 + i - 64), 1'b0);
    check("s3_in_ready_full", in_ready, 0);
    check("s3_valid", out_valid, 1);
    check("s3_a_d0", out_data[0], 16'h0100);
    check("s3_a_d63", out_data[63], 16'h013F);
    for (int i = 0; i < 64; i++) snap[i] = out_data[i];
    diffs = 0;
    repeat (20) begin
      tick(1);
      for (int i = 0; i < 64; i++) if (out_data[i] !== snap[i]) diffs++;
    end
    check("s3_stable", diffs, 0);
    check("s3_still_full", in_ready, 0);
    out_ready = 1'b1;
    check("s3_ready_same_cycle", in_ready, 0);
    tick(1);
    out_ready = 1'b0;
    check("s3_b_valid", out_valid, 1);
    check("s3_b_d0", out_data[0], 16'h0200);
    check("s3_b_d1", out_data[1], 16'h0201);
    check("s3_b_d63", out_data[63], 16'h023F);
    check("s3_in_ready_freed", in_ready, 1);
    out_ready = 1'b1;
    tick(1);
    out_ready = 1'b0;
    check("s3_drained", out_valid, 0);

    // 4: reset in the middle of a block
    for (int i = 0; i < 20; i++) send(16'(16'h0300 + i), 1'b0);
    reset_n = 1'b0;
    tick(2);
    check("s4_rst_out_valid", out_valid, 0);
    check("s4_rst_in_ready", in_ready, 0);
    reset_n = 1'b1;
    tick(1);
    check("s4_in_ready", in_ready, 1);
    check("s4_out_valid", out_valid, 0);
    send(16'h0011, 1'b0);
    send(16'h0022, 1'b0);
    send(16'h0033, 1'b1);
    check("s4_valid", out_valid, 1);
    check("s4_d0", out_data[0], 16'h0011);
    check("s4_d1", out_data[1], 16'h0022);
    check("s4_d8", out_data[8], 16'h0033);
    check("s4_zeros", stray_nonzero(), 0);
    out_ready = 1'b1;
    tick(1);

    // 5: four blocks streamed back to back
    acc_cnt   = 0;
    hs_n      = 0;
    ready_low = 1'b0;
    mon_en    = 1'b1;
    for (int i = 0; i < 256; i++) send(16'(i), 1'b0);
    tick(1);
    mon_en = 1'b0;
    check("s5_accepts", acc_cnt, 256);
    check("s5_accept_span", last_acc - first_acc, 255);
    check("s5_ready_low", ready_low, 0);
    check("s5_handshakes", hs_n, 4);
    check("s5_gap01", hs_cyc[1] - hs_cyc[0], 64);
    check("s5_gap12", hs_cyc[2] - hs_cyc[1], 64);
    check("s5_gap23", hs_cyc[3] - hs_cyc[2], 64);

    // 6: in_valid toggling every other cycle
    acc_cnt = 0;
    hs_n    = 0;
    mon_en  = 1'b1;
    for (int i = 0; i < 64; i++) begin
      send(16'(i), 1'b0);
      if (i == 62) check("s6_valid_early", out_valid, 0);
      if (i < 63) tick(1);
    end
    check_ramp_block("s6");
    check("s6_accepts", acc_cnt, 64);
    tick(1);
    mon_en = 1'b0;
    check("s6_consumed", out_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
